// File: rtl/cpu_agu_pkg.sv
// Shared types and constants for the address-generation unit.
package cpu_agu_pkg;

  typedef enum logic [2:0] {
    ABS     = 3'd0,
    ABS_IDX = 3'd1,
    ZP      = 3'd2,
    ZP_IDX  = 3'd3,
    X_IND   = 3'd4,
    IND_Y   = 3'd5
  } agu_mode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_OP_LO,
    S_OP_HI,
    S_ZP_IDX,
    S_PTR_LO,
    S_PTR_HI,
    S_FIX,
    S_DONE
  } agu_state_e;

  // Edges from the start sample to the done pulse, for the core's sequencer.
  localparam int LAT_ZP          = 2;
  localparam int LAT_ABS         = 3;
  localparam int LAT_ZP_IDX      = 3;
  localparam int LAT_ABS_IDX     = 3;
  localparam int LAT_ABS_IDX_FIX = 4;
  localparam int LAT_X_IND       = 5;
  localparam int LAT_IND_Y       = 4;
  localparam int LAT_IND_Y_FIX   = 5;

  // Unused encodings behave as absolute addressing.
  function automatic agu_mode_e decode_mode(input logic [2:0] raw);
    if (raw > 3'd5) return ABS;
    return agu_mode_e'(raw);
  endfunction

endpackage

// File: rtl/cpu_agu_adder.sv
// DATA_W-bit adder with carry-out, shared by all index/pointer arithmetic.
module cpu_agu_adder #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_sum,
  output logic              o_carry
);

  assign {o_carry, o_sum} = {1'b0, i_a} + {1'b0, i_b};

endmodule

// File: rtl/cpu_agu.sv
// Multi-cycle effective-address generator; all state advances on negedge clk.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | waiting for start
// S_OP_LO  | reading first operand byte
// S_OP_HI  | reading second operand byte (absolute modes)
// S_ZP_IDX | dummy read of base zero-page address while indexing
// S_PTR_LO | reading pointer low byte from zero page
// S_PTR_HI | reading pointer high byte from zero page
// S_FIX    | dummy read at uncorrected address, high byte fix-up
// S_DONE   | ea complete; next edge pulses done
module cpu_agu
  import cpu_agu_pkg::*;
#(
  parameter int              DATA_W    = 8,
  parameter logic [DATA_W-1:0] ZP_HI   = '0,
  parameter bit              FORCE_FIX = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [2:0]          mode,
  input  logic                is_write,
  input  logic [2*DATA_W-1:0] pc,
  input  logic [DATA_W-1:0]   index,
  input  logic [DATA_W-1:0]   data_in,
  output logic [2*DATA_W-1:0] adr_out,
  output logic                consume,
  output logic                dummy,
  output logic                busy,
  output logic                done,
  output logic [2*DATA_W-1:0] ea,
  output logic                page_cross
);

  localparam int AW = 2 * DATA_W;

  agu_state_e        r_state, w_state_nxt;
  agu_mode_e         r_mode, w_mode_nxt;
  logic              r_write, w_write_nxt;
  logic [AW-1:0]     r_pc, w_pc_nxt;
  logic [DATA_W-1:0] r_lo, w_lo_nxt;
  logic [DATA_W-1:0] r_hi, w_hi_nxt;
  logic [DATA_W-1:0] r_zp, w_zp_nxt;
  logic [AW-1:0]     r_adr, w_adr_nxt;
  logic              r_consume, w_consume_nxt;
  logic              r_dummy, w_dummy_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;
  logic [AW-1:0]     r_ea, w_ea_nxt;
  logic              r_page_cross, w_page_cross_nxt;

  logic [DATA_W-1:0] w_add_a, w_add_b, w_sum;
  logic              w_carry, w_indexed, w_fix;

  // Steer the shared adder operands by state.
  always_comb begin
    w_add_a = r_lo;
    w_add_b = index;
    case (r_state)
      S_PTR_LO: begin w_add_a = r_zp; w_add_b = DATA_W'(1); end
      S_FIX:    begin w_add_a = r_hi; w_add_b = {{(DATA_W-1){1'b0}}, r_page_cross}; end
      default: ;
    endcase
  end

  cpu_agu_adder #(.DATA_W(DATA_W)) u_adder (
    .i_a    (w_add_a),
    .i_b    (w_add_b),
    .o_sum  (w_sum),
    .o_carry(w_carry)
  );

  assign w_indexed = (r_mode == ABS_IDX) || (r_mode == IND_Y);
  assign w_fix     = w_carry | r_write | FORCE_FIX;

  // Next-state and next-output decode; every register holds unless a state updates it.
  always_comb begin
    w_state_nxt      = r_state;
    w_mode_nxt       = r_mode;
    w_write_nxt      = r_write;
    w_pc_nxt         = r_pc;
    w_lo_nxt         = r_lo;
    w_hi_nxt         = r_hi;
    w_zp_nxt         = r_zp;
    w_adr_nxt        = r_adr;
    w_consume_nxt    = 1'b0;
    w_dummy_nxt      = 1'b0;
    w_busy_nxt       = r_busy;
    w_done_nxt       = 1'b0;
    w_ea_nxt         = r_ea;
    w_page_cross_nxt = r_page_cross;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_mode_nxt       = decode_mode(mode);
          w_write_nxt      = is_write;
          w_pc_nxt         = pc;
          w_adr_nxt        = pc;
          w_busy_nxt       = 1'b1;
          w_ea_nxt         = '0;
          w_page_cross_nxt = 1'b0;
          w_state_nxt      = S_OP_LO;
        end
      end
      S_OP_LO: begin
        w_lo_nxt      = data_in;
        w_zp_nxt      = data_in;
        w_consume_nxt = 1'b1;
        case (r_mode)
          ZP: begin
            w_ea_nxt    = {ZP_HI, data_in};
            w_state_nxt = S_DONE;
          end
          ZP_IDX, X_IND: begin
            w_adr_nxt   = {ZP_HI, data_in};
            w_dummy_nxt = 1'b1;
            w_state_nxt = S_ZP_IDX;
          end
          IND_Y: begin
            w_adr_nxt   = {ZP_HI, data_in};
            w_state_nxt = S_PTR_LO;
          end
          default: begin
            w_adr_nxt   = r_pc + AW'(1);
            w_state_nxt = S_OP_HI;
          end
        endcase
      end
      S_ZP_IDX: begin
        // Zero-page indexing never carries into the page.
        w_zp_nxt = w_sum;
        if (r_mode == X_IND) begin
          w_adr_nxt   = {ZP_HI, w_sum};
          w_state_nxt = S_PTR_LO;
        end else begin
          w_ea_nxt    = {ZP_HI, w_sum};
          w_state_nxt = S_DONE;
        end
      end
      S_PTR_LO: begin
        w_lo_nxt    = data_in;
        w_adr_nxt   = {ZP_HI, w_sum};
        w_state_nxt = S_PTR_HI;
      end
      S_OP_HI, S_PTR_HI: begin
        w_consume_nxt = (r_state == S_OP_HI);
        if (!w_indexed) begin
          w_ea_nxt    = {data_in, r_lo};
          w_state_nxt = S_DONE;
        end else begin
          w_page_cross_nxt = w_carry;
          w_lo_nxt         = w_sum;
          w_hi_nxt         = data_in;
          if (w_fix) begin
            w_adr_nxt   = {data_in, w_sum};
            w_dummy_nxt = 1'b1;
            w_state_nxt = S_FIX;
          end else begin
            w_ea_nxt    = {data_in, w_sum};
            w_state_nxt = S_DONE;
          end
        end
      end
      S_FIX: begin
        w_ea_nxt    = {w_sum, r_lo};
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_done_nxt  = 1'b1;
        w_busy_nxt  = 1'b0;
        w_adr_nxt   = r_ea;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and output registers, updated on the core's falling edge.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_mode       <= ABS;
      r_write      <= 1'b0;
      r_pc         <= '0;
      r_lo         <= '0;
      r_hi         <= '0;
      r_zp         <= '0;
      r_adr        <= '0;
      r_consume    <= 1'b0;
      r_dummy      <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_ea         <= '0;
      r_page_cross <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_mode       <= w_mode_nxt;
      r_write      <= w_write_nxt;
      r_pc         <= w_pc_nxt;
      r_lo         <= w_lo_nxt;
      r_hi         <= w_hi_nxt;
      r_zp         <= w_zp_nxt;
      r_adr        <= w_adr_nxt;
      r_consume    <= w_consume_nxt;
      r_dummy      <= w_dummy_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_ea         <= w_ea_nxt;
      r_page_cross <= w_page_cross_nxt;
    end
  end

  assign adr_out    = r_adr;
  assign consume    = r_consume;
  assign dummy      = r_dummy;
  assign busy       = r_busy;
  assign done       = r_done;
  assign ea         = r_ea;
  assign page_cross = r_page_cross;

endmodule

// File: tb/tb_cpu_agu.sv
// Directed bench for cpu_agu: DUT acts on negedge, bench drives and samples on posedge.
module tb_cpu_agu;
  import cpu_agu_pkg::*;

  logic        clk = 1'b1;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  mode = 3'd0;
  logic        is_write = 1'b0;
  logic [15:0] pc = 16'h0;
  logic [7:0]  index = 8'h0;
  logic [7:0]  data_in;
  logic [15:0] adr_out, ea;
  logic        consume, dummy, busy, done, page_cross;

  logic [7:0]  mem [0:65535];
  int          total = 0;
  int          bad = 0;

  int          res_edge, res_consumes, res_dummies;
  logic [15:0] res_dummy_adr, res_ea, res_adr;
  logic        res_pcr, res_busy;

  always #5 clk = ~clk;

  assign data_in = mem[adr_out];

  cpu_agu dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .is_write(is_write),
    .pc(pc), .index(index), .data_in(data_in), .adr_out(adr_out), .consume(consume),
    .dummy(dummy), .busy(busy), .done(done), .ea(ea), .page_cross(page_cross)
  );

  // Called just after a posedge; start is sampled on the next negedge (edge 0).
  task automatic run_seq(input logic [2:0] m, input logic w, input logic [15:0] p,
                         input logic [7:0] idx, input bit hold);
    mode = m; is_write = w; pc = p; index = idx; start = 1'b1;
    res_edge = -1; res_consumes = 0; res_dummies = 0; res_dummy_adr = 16'h0;
    res_ea = 16'h0; res_adr = 16'h0; res_pcr = 1'b0; res_busy = 1'b1;
    @(negedge clk);
    @(posedge clk);
    if (!hold) start = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      @(posedge clk);
      if (consume) res_consumes++;
      if (dummy) begin res_dummies++; res_dummy_adr = adr_out; end
      if (done) begin
        res_edge = k; res_ea = ea; res_pcr = page_cross; res_busy = busy; res_adr = adr_out;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++; if (adr_out !== 16'h0) begin bad++; $display("FAIL reset_adr: got %h want 0000", adr_out); end
    total++; if ({consume, dummy, page_cross} !== 3'b000) begin bad++; $display("FAIL reset_flags: got %b want 000", {consume, dummy, page_cross}); end
    total++; if (ea !== 16'h0) begin bad++; $display("FAIL reset_ea: got %h want 0000", ea); end
    reset = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_abs;
    mem[16'h8001] = 8'h34; mem[16'h8002] = 8'h12;
    run_seq(ABS, 1'b0, 16'h8001, 8'h00, 1'b0);
    total++; if (res_edge != 3) begin bad++; $display("FAIL abs_latency: got %0d want 3", res_edge); end
    total++; if (res_consumes != 2) begin bad++; $display("FAIL abs_consume: got %0d want 2", res_consumes); end
    total++; if (res_ea !== 16'h1234) begin bad++; $display("FAIL abs_ea: got %h want 1234", res_ea); end
    total++; if (res_pcr !== 1'b0) begin bad++; $display("FAIL abs_pcross: got %b want 0", res_pcr); end
    total++; if (res_dummies != 0) begin bad++; $display("FAIL abs_dummy: got %0d want 0", res_dummies); end
    total++; if (res_adr !== 16'h1234) begin bad++; $display("FAIL abs_adr_at_done: got %h want 1234", res_adr); end
    total++; if (res_busy !== 1'b0) begin bad++; $display("FAIL abs_busy_at_done: got %b want 0", res_busy); end
  endtask

  task automatic test_abs_idx;
    mem[16'h8010] = 8'hF8; mem[16'h8011] = 8'h12;
    run_seq(ABS_IDX, 1'b0, 16'h8010, 8'h10, 1'b0);
    total++; if (res_edge != 4) begin bad++; $display("FAIL absx_cross_latency: got %0d want 4", res_edge); end
    total++; if (res_dummy_adr !== 16'h1208 || res_dummies != 1) begin bad++; $display("FAIL absx_cross_dummy: got %h/%0d want 1208/1", res_dummy_adr, res_dummies); end
    total++; if (res_ea !== 16'h1308) begin bad++; $display("FAIL absx_cross_ea: got %h want 1308", res_ea); end
    total++; if (res_pcr !== 1'b1) begin bad++; $display("FAIL absx_cross_pcross: got %b want 1", res_pcr); end
    total++; if (res_consumes != 2) begin bad++; $display("FAIL absx_cross_consume: got %0d want 2", res_consumes); end
    run_seq(ABS_IDX, 1'b0, 16'h8010, 8'h01, 1'b0);
    total++; if (res_edge != 3) begin bad++; $display("FAIL absx_nocross_latency: got %0d want 3", res_edge); end
    total++; if (res_dummies != 0) begin bad++; $display("FAIL absx_nocross_dummy: got %0d want 0", res_dummies); end
    total++; if (res_ea !== 16'h12F9) begin bad++; $display("FAIL absx_nocross_ea: got %h want 12f9", res_ea); end
    total++; if (res_pcr !== 1'b0) begin bad++; $display("FAIL absx_nocross_pcross: got %b want 0", res_pcr); end
  endtask

  task automatic test_abs_idx_write;
    mem[16'h8020] = 8'h00; mem[16'h8021] = 8'h20;
    run_seq(ABS_IDX, 1'b1, 16'h8020, 8'h01, 1'b0);
    total++; if (res_edge != 4) begin bad++; $display("FAIL absx_wr_latency: got %0d want 4", res_edge); end
    total++; if (res_dummy_adr !== 16'h2001 || res_dummies != 1) begin bad++; $display("FAIL absx_wr_dummy: got %h/%0d want 2001/1", res_dummy_adr, res_dummies); end
    total++; if (res_ea !== 16'h2001) begin bad++; $display("FAIL absx_wr_ea: got %h want 2001", res_ea); end
    total++; if (res_pcr !== 1'b0) begin bad++; $display("FAIL absx_wr_pcross: got %b want 0", res_pcr); end
  endtask

  task automatic test_zp;
    mem[16'h8030] = 8'h77;
    run_seq(ZP, 1'b0, 16'h8030, 8'h55, 1'b0);
    total++; if (res_edge != 2) begin bad++; $display("FAIL zp_latency: got %0d want 2", res_edge); end
    total++; if (res_ea !== 16'h0077) begin bad++; $display("FAIL zp_ea: got %h want 0077", res_ea); end
    total++; if (res_consumes != 1) begin bad++; $display("FAIL zp_consume: got %0d want 1", res_consumes); end
  endtask

  // start held high for the whole sequence must not restart it.
  task automatic test_zp_idx;
    mem[16'h8040] = 8'hF0;
    run_seq(ZP_IDX, 1'b0, 16'h8040, 8'h20, 1'b1);
    total++; if (res_edge != 3) begin bad++; $display("FAIL zpx_latency: got %0d want 3", res_edge); end
    total++; if (res_dummy_adr !== 16'h00F0 || res_dummies != 1) begin bad++; $display("FAIL zpx_dummy: got %h/%0d want 00f0/1", res_dummy_adr, res_dummies); end
    total++; if (res_ea !== 16'h0010) begin bad++; $display("FAIL zpx_ea: got %h want 0010", res_ea); end
    total++; if (res_consumes != 1) begin bad++; $display("FAIL zpx_consume: got %0d want 1", res_consumes); end
    total++; if (res_pcr !== 1'b0) begin bad++; $display("FAIL zpx_pcross: got %b want 0", res_pcr); end
  endtask

  task automatic test_x_ind;
    mem[16'h8050] = 8'hFE; mem[16'h00FF] = 8'h00; mem[16'h0000] = 8'h30;
    run_seq(X_IND, 1'b0, 16'h8050, 8'h01, 1'b0);
    total++; if (res_edge != 5) begin bad++; $display("FAIL xind_latency: got %0d want 5", res_edge); end
    total++; if (res_ea !== 16'h3000) begin bad++; $display("FAIL xind_ea: got %h want 3000", res_ea); end
    total++; if (res_consumes != 1) begin bad++; $display("FAIL xind_consume: got %0d want 1", res_consumes); end
    total++; if (res_dummy_adr !== 16'h00FE || res_dummies != 1) begin bad++; $display("FAIL xind_dummy: got %h/%0d want 00fe/1", res_dummy_adr, res_dummies); end
  endtask

  task automatic test_ind_y;
    mem[16'h8060] = 8'h40; mem[16'h0040] = 8'hFF; mem[16'h0041] = 8'hFF;
    run_seq(IND_Y, 1'b0, 16'h8060, 8'h01, 1'b0);
    total++; if (res_edge != 5) begin bad++; $display("FAIL indy_latency: got %0d want 5", res_edge); end
    total++; if (res_ea !== 16'h0000) begin bad++; $display("FAIL indy_ea: got %h want 0000", res_ea); end
    total++; if (res_pcr !== 1'b1) begin bad++; $display("FAIL indy_pcross: got %b want 1", res_pcr); end
    total++; if (res_dummy_adr !== 16'hFF00 || res_dummies != 1) begin bad++; $display("FAIL indy_dummy: got %h/%0d want ff00/1", res_dummy_adr, res_dummies); end
    total++; if (res_consumes != 1) begin bad++; $display("FAIL indy_consume: got %0d want 1", res_consumes); end
  endtask

  task automatic test_illegal_mode;
    mem[16'h8070] = 8'hCD; mem[16'h8071] = 8'hAB;
    run_seq(3'd7, 1'b0, 16'h8070, 8'h05, 1'b0);
    total++; if (res_edge != 3) begin bad++; $display("FAIL illegal_latency: got %0d want 3", res_edge); end
    total++; if (res_ea !== 16'hABCD) begin bad++; $display("FAIL illegal_ea: got %h want abcd", res_ea); end
    total++; if (res_consumes != 2) begin bad++; $display("FAIL illegal_consume: got %0d want 2", res_consumes); end
  endtask

  // Second start is raised right after done and must be taken on the following edge.
  task automatic test_back_to_back;
    run_seq(ZP, 1'b0, 16'h8030, 8'h00, 1'b0);
    run_seq(ABS, 1'b0, 16'h8001, 8'h00, 1'b0);
    total++; if (res_edge != 3) begin bad++; $display("FAIL b2b_latency: got %0d want 3", res_edge); end
    total++; if (res_ea !== 16'h1234) begin bad++; $display("FAIL b2b_ea: got %h want 1234", res_ea); end
  endtask

  task automatic test_reset_mid;
    int dones;
    dones = 0;
    mode = IND_Y; is_write = 1'b0; pc = 16'h8060; index = 8'h01; start = 1'b1;
    @(negedge clk);
    @(posedge clk); start = 1'b0;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    @(posedge clk); reset = 1'b1;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midreset_busy: got %b want 0", busy); end
    total++; if (adr_out !== 16'h0 || ea !== 16'h0) begin bad++; $display("FAIL midreset_bus: got %h/%h want 0000/0000", adr_out, ea); end
    total++; if ({consume, dummy, page_cross} !== 3'b000) begin bad++; $display("FAIL midreset_flags: got %b want 000", {consume, dummy, page_cross}); end
    @(posedge clk); reset = 1'b0;
    repeat (6) begin
      @(negedge clk);
      @(posedge clk);
      if (done) dones++;
    end
    total++; if (dones != 0) begin bad++; $display("FAIL midreset_no_done: got %0d want 0", dones); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midreset_idle: got %b want 0", busy); end
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
    test_reset;
    test_abs;
    test_abs_idx;
    test_abs_idx_write;
    test_zp;
    test_zp_idx;
    test_x_ind;
    test_ind_y;
    test_illegal_mode;
    test_back_to_back;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
